// File: rtl/data_memory_ctrl.sv
// Byte-addressed, word-organised data memory behind a valid/ready request port.
// Byte/half/word loads and stores, with a programmable read latency and fault detection.
module data_memory_ctrl #(
  parameter string       DATA_MEMFILE = "",
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error
);

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0]  LOAD_CNT = 2'(READ_LATENCY - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  logic [31:0] mem [DEPTH];

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        fire_d, error_d;
  logic [31:0] rdata_d;

  logic        accept_c;
  logic        err_c;
  logic [AW-1:0] idx_c;
  logic [31:0] mem_word_c;
  logic [3:0]  be_c;
  logic [31:0] wdata_al_c;

  logic [31:0] hold_q;
  logic [1:0]  lane_q, size_q;
  logic        uns_q, wr_q, err_q;

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] lane,
                                         input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = w[{lane[1], 4'b0000} +: 16];
    case (size)
      2'b00:   extend = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      2'b01:   extend = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: extend = w;
    endcase
  endfunction

  assign req_ready  = (state_q == IDLE) && !reset;
  assign accept_c   = req_valid && req_ready;
  assign idx_c      = req_addr[AW+1:2];
  assign mem_word_c = mem[idx_c];

  // Full 30-bit index compare so high addresses never alias into the array.
  assign err_c = (req_size == 2'b11)
               || ((req_size == 2'b01) && req_addr[0])
               || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
               || ({2'b00, req_addr[31:2]} >= 32'(DEPTH));

  // Store lane enables and replicated write data.
  always_comb begin
    be_c       = 4'b0000;
    wdata_al_c = req_wdata;
    case (req_size)
      2'b00: begin
        be_c       = 4'(4'b0001 << req_addr[1:0]);
        wdata_al_c = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_c       = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_al_c = {2{req_wdata[15:0]}};
      end
      2'b10:   be_c = 4'b1111;
      default: be_c = 4'b0000;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fire_d  = 1'b0;
    error_d = 1'b0;
    rdata_d = 32'h0;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d = BUSY;
          cnt_d   = req_write ? 2'd0 : LOAD_CNT;
          // Response lands in the first BUSY cycle: build it straight from the request.
          if (req_write || (LOAD_CNT == 2'd0)) begin
            fire_d  = 1'b1;
            error_d = err_c;
            if (!req_write && !err_c)
              rdata_d = extend(mem_word_c, req_addr[1:0], req_size, req_unsigned);
          end
        end
      end
      BUSY: begin
        if (cnt_q == 2'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 2'd1;
          if (cnt_q == 2'd1) begin
            fire_d  = 1'b1;
            error_d = err_q;
            if (!wr_q && !err_q)
              rdata_d = extend(hold_q, lane_q, size_q, uns_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_error <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      resp_valid <= fire_d;
      resp_rdata <= rdata_d;
      resp_error <= error_d;
    end
  end

  // Request capture for the delayed load response.
  always_ff @(posedge clk) begin
    if (accept_c) begin
      hold_q <= mem_word_c;
      lane_q <= req_addr[1:0];
      size_q <= req_size;
      uns_q  <= req_unsigned;
      wr_q   <= req_write;
      err_q  <= err_c;
    end
  end

  always_ff @(posedge clk) begin
    if (accept_c && req_write && !err_c) begin
      for (int i = 0; i < 4; i++) begin
        if (be_c[i]) mem[idx_c][8*i +: 8] <= wdata_al_c[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: three instances cover latency 1, 3 (depth 16) and 2.
module tb_data_memory_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic [2:0]        req_valid, req_ready, req_write, req_unsigned, resp_valid, resp_error;
  logic [2:0][1:0]   req_size;
  logic [2:0][31:0]  req_addr, req_wdata, resp_rdata;

  int vectors = 0;
  int errors  = 0;
  int lat [3] = '{1, 3, 2};

  always #5 clk = ~clk;

  data_memory_ctrl #(.DATA_MEMFILE(""), .DEPTH(1024), .READ_LATENCY(1)) u0 (
    .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr[0]), .req_write(req_write[0]), .req_size(req_size[0]),
    .req_unsigned(req_unsigned[0]), .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]),
    .resp_rdata(resp_rdata[0]), .resp_error(resp_error[0]));

  data_memory_ctrl #(.DATA_MEMFILE(""), .DEPTH(16), .READ_LATENCY(3)) u1 (
    .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr[1]), .req_write(req_write[1]), .req_size(req_size[1]),
    .req_unsigned(req_unsigned[1]), .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]),
    .resp_rdata(resp_rdata[1]), .resp_error(resp_error[1]));

  data_memory_ctrl #(.DATA_MEMFILE(""), .DEPTH(1024), .READ_LATENCY(2)) u2 (
    .clk(clk), .reset(reset), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_addr(req_addr[2]), .req_write(req_write[2]), .req_size(req_size[2]),
    .req_unsigned(req_unsigned[2]), .req_wdata(req_wdata[2]), .resp_valid(resp_valid[2]),
    .resp_rdata(resp_rdata[2]), .resp_error(resp_error[2]));

  // One request on instance d, then latency, payload, busy-ready and return-to-idle checks.
  task automatic access(input int d, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_data, input logic exp_err, input string name);
    int n;
    int exp_lat;
    logic got, busy_ok, re;
    logic [31:0] rd;
    exp_lat = wr ? 1 : lat[d];
    @(negedge clk);
    vectors++;
    if (req_ready[d] !== 1'b1) begin
      errors++; $display("FAIL %s ready_before got %b want 1", name, req_ready[d]);
    end
    req_valid[d] = 1'b1; req_write[d] = wr; req_size[d] = sz;
    req_unsigned[d] = uns; req_addr[d] = addr; req_wdata[d] = wd;
    @(posedge clk); #1;
    req_valid[d] = 1'b0; req_addr[d] = $urandom; req_wdata[d] = $urandom;
    req_write[d] = 1'b1; req_size[d] = 2'($urandom); req_unsigned[d] = 1'($urandom);
    n = 0; got = 1'b0; busy_ok = 1'b1; rd = 32'h0; re = 1'b0;
    while (!got && n < 8) begin
      @(negedge clk);
      n++;
      if (resp_valid[d] === 1'b1) begin got = 1'b1; rd = resp_rdata[d]; re = resp_error[d]; end
      if (req_ready[d] !== 1'b0) busy_ok = 1'b0;
    end
    vectors++;
    if (!got || n != exp_lat) begin
      errors++; $display("FAIL %s latency got %0d (seen %b) want %0d", name, n, got, exp_lat);
    end
    vectors++;
    if (rd !== exp_data) begin
      errors++; $display("FAIL %s rdata got %h want %h", name, rd, exp_data);
    end
    vectors++;
    if (re !== exp_err) begin
      errors++; $display("FAIL %s error got %b want %b", name, re, exp_err);
    end
    vectors++;
    if (!busy_ok) begin
      errors++; $display("FAIL %s busy_ready got high want low", name);
    end
    @(negedge clk);
    vectors++;
    if ({resp_valid[d], req_ready[d], resp_error[d]} !== 3'b010 || resp_rdata[d] !== 32'h0) begin
      errors++;
      $display("FAIL %s idle got v=%b r=%b e=%b d=%h want v=0 r=1 e=0 d=0", name,
               resp_valid[d], req_ready[d], resp_error[d], resp_rdata[d]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (req_ready !== 3'b000 || resp_valid !== 3'b000 || resp_error !== 3'b000 ||
        resp_rdata !== '0) begin
      errors++; $display("FAIL reset_outputs got ready=%b valid=%b err=%b want all 0",
                         req_ready, resp_valid, resp_error);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (req_ready !== 3'b111 || resp_valid !== 3'b000) begin
      errors++; $display("FAIL reset_release got ready=%b valid=%b want 111/000", req_ready, resp_valid);
    end
  endtask

  task automatic test_word(input int d);
    access(d, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "store_word");
    access(d, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "load_word");
  endtask

  task automatic test_lanes(input int d);
    access(d, 1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFFFF5A, 32'h0, 1'b0, "store_byte");
    access(d, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD5AEF, 1'b0, "load_merged");
    access(d, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, "load_sbyte");
    access(d, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h000000DE, 1'b0, "load_ubyte");
    access(d, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0, "load_shalf");
    access(d, 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 32'h00005AEF, 1'b0, "load_uhalf");
  endtask

  task automatic test_errors(input int d);
    access(d, 1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1, "err_ld_half");
    access(d, 1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1, "err_ld_word");
    access(d, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, "err_ld_size");
    access(d, 1'b1, 2'b01, 1'b0, 32'h11, 32'h0000FFFF, 32'h0, 1'b1, "err_st_half");
    access(d, 1'b1, 2'b10, 1'b0, 32'h12, 32'h00000000, 32'h0, 1'b1, "err_st_word");
    access(d, 1'b1, 2'b11, 1'b0, 32'h10, 32'h00000000, 32'h0, 1'b1, "err_st_size");
    access(d, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD5AEF, 1'b0, "err_no_write");
  endtask

  task automatic test_depth(input int d);
    access(d, 1'b1, 2'b10, 1'b0, 32'h00, 32'hCAFEF00D, 32'h0, 1'b0, "dep_store0");
    access(d, 1'b1, 2'b10, 1'b0, 32'h40, 32'h12345678, 32'h0, 1'b1, "dep_store_oor");
    access(d, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h0, 1'b1, "dep_load_oor");
    access(d, 1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 32'hCAFEF00D, 1'b0, "dep_load0");
    access(d, 1'b1, 2'b10, 1'b0, 32'h3C, 32'h0BADCAFE, 32'h0, 1'b0, "dep_store_top");
    access(d, 1'b0, 2'b10, 1'b0, 32'h3C, 32'h0, 32'h0BADCAFE, 1'b0, "dep_load_top");
    access(d, 1'b1, 2'b10, 1'b0, 32'h80000010, 32'h11111111, 32'h0, 1'b1, "dep_alias_st");
    access(d, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD5AEF, 1'b0, "dep_no_alias");
  endtask

  task automatic test_reset_mid(input int d);
    logic seen;
    @(negedge clk);
    req_valid[d] = 1'b1; req_write[d] = 1'b0; req_size[d] = 2'b10;
    req_unsigned[d] = 1'b0; req_addr[d] = 32'h10; req_wdata[d] = 32'h0;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (req_ready[d] !== 1'b0 || resp_valid[d] !== 1'b0) begin
      errors++; $display("FAIL rstmid_during got ready=%b valid=%b want 0/0", req_ready[d], resp_valid[d]);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (req_ready[d] !== 1'b1 || resp_valid[d] !== 1'b0 || resp_error[d] !== 1'b0 ||
        resp_rdata[d] !== 32'h0) begin
      errors++; $display("FAIL rstmid_after got ready=%b valid=%b err=%b d=%h want 1/0/0/0",
                         req_ready[d], resp_valid[d], resp_error[d], resp_rdata[d]);
    end
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid[d] !== 1'b0) seen = 1'b1;
    end
    vectors++;
    if (seen) begin
      errors++; $display("FAIL rstmid_no_resp got resp_valid 1 want 0");
    end
    access(d, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD5AEF, 1'b0, "rstmid_mem_kept");
  endtask

  task automatic test_back_to_back(input int d);
    logic [31:0] sa [4];
    logic [1:0]  ss [4];
    logic        su [4];
    logic [31:0] se [4];
    int acc [4];
    int rsp [4];
    logic [31:0] rdat [4];
    int na, nr;
    sa = '{32'h20, 32'h21, 32'h22, 32'h22};
    ss = '{2'b10, 2'b00, 2'b01, 2'b00};
    su = '{1'b0, 1'b0, 1'b0, 1'b1};
    se = '{32'h80FF7F01, 32'h0000007F, 32'hFFFF80FF, 32'h000000FF};
    access(d, 1'b1, 2'b10, 1'b0, 32'h20, 32'h80FF7F01, 32'h0, 1'b0, "b2b_store");
    na = 0; nr = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (resp_valid[d] === 1'b1) begin
        if (nr < 4) begin rsp[nr] = c; rdat[nr] = resp_rdata[d]; end
        nr++;
      end
      if (na < 4 && req_ready[d] === 1'b1) begin
        req_valid[d] = 1'b1; req_write[d] = 1'b0; req_addr[d] = sa[na];
        req_size[d] = ss[na]; req_unsigned[d] = su[na]; req_wdata[d] = 32'h0;
        acc[na] = c; na++;
      end else if (na < 4) begin
        req_valid[d] = 1'b1; req_write[d] = 1'b1; req_size[d] = 2'b00;
        req_addr[d] = 32'h20 | 32'($urandom_range(0, 3)); req_wdata[d] = $urandom;
        req_unsigned[d] = 1'($urandom);
      end else begin
        req_valid[d] = 1'b0;
      end
    end
    req_valid[d] = 1'b0;
    vectors++;
    if (na != 4 || nr != 4) begin
      errors++; $display("FAIL b2b_counts got acc=%0d resp=%0d want 4/4", na, nr);
    end
    for (int k = 0; k < 4; k++) begin
      if (k < na) begin
        vectors++;
        if (acc[k] != 3 * k) begin
          errors++; $display("FAIL b2b_accept%0d got cycle %0d want %0d", k, acc[k], 3 * k);
        end
      end
      if (k < nr) begin
        vectors++;
        if (rsp[k] != 3 * k + 2) begin
          errors++; $display("FAIL b2b_resp%0d got cycle %0d want %0d", k, rsp[k], 3 * k + 2);
        end
        vectors++;
        if (rdat[k] !== se[k]) begin
          errors++; $display("FAIL b2b_data%0d got %h want %h", k, rdat[k], se[k]);
        end
      end
    end
    access(d, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h80FF7F01, 1'b0, "b2b_mem_intact");
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0; req_write = '0; req_unsigned = '0;
    req_size = '0; req_addr = '0; req_wdata = '0;
    test_reset();
    test_word(0);
    test_word(1);
    test_lanes(0);
    test_lanes(1);
    test_errors(0);
    test_depth(1);
    test_reset_mid(1);
    test_back_to_back(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
